// File: rtl/duc_sched_pkg.sv
// Shared command codes, scheduler state encoding and error-bit positions
// for the DUC frame loader/scheduler.
package duc_sched_pkg;

  localparam logic [15:0] CMD_LOAD = 16'h5555;
  localparam logic [15:0] CMD_DONE = 16'h8888;
  localparam logic [15:0] CMD_PLAY = 16'hFFFF;
  localparam logic [15:0] CMD_STOP = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_PLAY     = 3'd3,
    ST_STOPPING = 3'd4
  } state_t;

  localparam int ERR_SHORT = 0;  // DONE issued before a full frame was loaded
  localparam int ERR_CMD   = 1;  // unknown code or code illegal in current state
  localparam int ERR_WR    = 2;  // sample write outside LOAD

endpackage

// File: rtl/duc_frame_ram.sv
// Simple dual-port frame RAM: one write port, one synchronous read port.
// Read data appears the cycle after re; no reset on contents.
module duc_frame_ram #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/duc_frame_sched.sv
// Local-bus frame loader and AXI-Stream replayer for the DUC baseband buffer.
// First tvalid 2 cycles after PLAY write; 2-entry skid buffer gives 1 word/cycle under tready.
module duc_frame_sched
  import duc_sched_pkg::*;
#(
  parameter int CMD_ADDR  = 16000,
  parameter int STAT_ADDR = 16001,
  parameter int BUF_BASE  = 12000,
  parameter int FRAME_LEN = 3840,
  parameter int RAM_AW    = 12
) (
  input  logic        lbs_clk,
  input  logic        rst_n,
  input  logic [13:0] lbs_addr,
  input  logic [31:0] lbs_din,
  input  logic        lbs_we,
  input  logic        lbs_re,
  output logic [31:0] lbs_dout,
  output logic        axis_tx_tvalid,
  output logic [31:0] axis_tx_tdata,
  output logic        axis_tx_tlast,
  input  logic        axis_tx_tready,
  output logic        busy
);

  localparam int                CW       = $clog2(FRAME_LEN + 1);
  localparam logic [13:0]       CMD_A    = 14'(CMD_ADDR);
  localparam logic [13:0]       STAT_A   = 14'(STAT_ADDR);
  localparam logic [13:0]       BUF_LO   = 14'(BUF_BASE);
  localparam logic [13:0]       BUF_HI   = 14'(BUF_BASE + FRAME_LEN);
  localparam logic [RAM_AW-1:0] LAST_A   = RAM_AW'(FRAME_LEN - 1);
  localparam logic [CW-1:0]     FULL_CNT = CW'(FRAME_LEN);

  state_t            state, state_nx;
  logic [2:0]        err, err_nx;
  logic [CW-1:0]     load_cnt;
  logic              load_clr;
  logic [15:0]       last_cmd, frame_cnt, code;
  logic [RAM_AW-1:0] rd_ptr, rd_addr, smp_off;
  logic              cmd_wr, smp_wr, play_go, ram_we;
  logic              fetch, inflight, inflight_last;
  logic [31:0]       ram_rdata;
  logic [32:0]       sk_mem [2];
  logic              sk_wp, sk_rp;
  logic [1:0]        sk_cnt, sk_room;
  logic              pop, head_last, stop_done;
  logic              re_q;
  logic [13:0]       ra_q;
  logic [31:0]       rd_val;

  assign code    = lbs_din[15:0];
  assign cmd_wr  = lbs_we && (lbs_addr == CMD_A);
  assign smp_wr  = lbs_we && (lbs_addr >= BUF_LO) && (lbs_addr < BUF_HI);
  assign smp_off = RAM_AW'(lbs_addr - BUF_LO);
  assign ram_we  = smp_wr && (state == ST_LOAD);
  assign play_go = cmd_wr && (code == CMD_PLAY) && (state == ST_ARMED);
  assign busy    = (state == ST_LOAD) || (state == ST_PLAY) || (state == ST_STOPPING);

  // Skid buffer output side; data is forced to zero while invalid.
  assign axis_tx_tvalid = (sk_cnt != 2'd0);
  assign head_last      = sk_mem[sk_rp][32];
  assign axis_tx_tlast  = axis_tx_tvalid && head_last;
  assign axis_tx_tdata  = axis_tx_tvalid ? sk_mem[sk_rp][31:0] : '0;
  assign pop            = axis_tx_tvalid && axis_tx_tready;
  assign stop_done      = (state == ST_STOPPING) && pop && head_last;

  // Fetch only if the word returning next cycle is guaranteed a free slot.
  // The first fetch is issued from the PLAY command cycle itself; in STOPPING
  // rd_ptr==0 means the frame's last address has already been fetched.
  assign sk_room = sk_cnt + {1'b0, inflight} - {1'b0, pop};
  assign fetch   = play_go ||
                   (!stop_done && (sk_room <= 2'd1) &&
                    ((state == ST_PLAY) || ((state == ST_STOPPING) && (rd_ptr != '0))));
  assign rd_addr = play_go ? '0 : rd_ptr;

  duc_frame_ram #(.AW(RAM_AW), .DW(32)) u_ram (
    .clk   (lbs_clk),
    .we    (ram_we),
    .waddr (smp_off),
    .wdata (lbs_din),
    .re    (fetch),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge lbs_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      err   <= '0;
    end else begin
      state <= state_nx;
      err   <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    err_nx   = err;
    load_clr = 1'b0;
    if (stop_done) state_nx = ST_ARMED;
    if (cmd_wr) begin
      if ((code == CMD_LOAD) && ((state == ST_IDLE) || (state == ST_ARMED))) begin
        state_nx = ST_LOAD;
        load_clr = 1'b1;
      end else if ((code == CMD_DONE) && (state == ST_LOAD)) begin
        if (load_cnt == FULL_CNT) begin
          state_nx = ST_ARMED;
        end else begin
          state_nx          = ST_IDLE;
          err_nx[ERR_SHORT] = 1'b1;
        end
      end else if (play_go) begin
        state_nx = ST_PLAY;
      end else if ((code == CMD_STOP) && (state == ST_PLAY)) begin
        state_nx = ST_STOPPING;
      end else begin
        err_nx[ERR_CMD] = 1'b1;
      end
    end
    if (smp_wr && (state != ST_LOAD)) err_nx[ERR_WR] = 1'b1;
  end

  always_ff @(posedge lbs_clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt      <= '0;
      last_cmd      <= '0;
      frame_cnt     <= '0;
      rd_ptr        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      sk_wp         <= 1'b0;
      sk_rp         <= 1'b0;
      sk_cnt        <= 2'd0;
    end else begin
      if (cmd_wr) last_cmd <= code;
      if (load_clr) load_cnt <= '0;
      else if (ram_we && (load_cnt != FULL_CNT)) load_cnt <= load_cnt + 1'b1;
      if (pop && head_last) frame_cnt <= frame_cnt + 1'b1;
      if (fetch) begin
        rd_ptr        <= (rd_addr == LAST_A) ? '0 : rd_addr + 1'b1;
        inflight_last <= (rd_addr == LAST_A);
      end
      // Leaving STOPPING discards any prefetched words of the next frame.
      if (stop_done) begin
        inflight <= 1'b0;
        sk_wp    <= 1'b0;
        sk_rp    <= 1'b0;
        sk_cnt   <= 2'd0;
      end else begin
        inflight <= fetch;
        if (inflight) sk_wp <= ~sk_wp;
        if (pop) sk_rp <= ~sk_rp;
        sk_cnt <= sk_cnt + {1'b0, inflight} - {1'b0, pop};
      end
    end
  end

  always_ff @(posedge lbs_clk) begin
    if (inflight && !stop_done) sk_mem[sk_wp] <= {inflight_last, ram_rdata};
  end

  always_comb begin
    rd_val = '0;
    if (ra_q == STAT_A)     rd_val = {frame_cnt, 9'b0, err, 1'b0, state};
    else if (ra_q == CMD_A) rd_val = {16'b0, last_cmd};
  end

  always_ff @(posedge lbs_clk or negedge rst_n) begin
    if (!rst_n) begin
      re_q     <= 1'b0;
      ra_q     <= '0;
      lbs_dout <= '0;
    end else begin
      re_q <= lbs_re;
      if (lbs_re) ra_q <= lbs_addr;
      if (re_q) lbs_dout <= rd_val;
    end
  end

endmodule
